mux2_rr_stream_sel: RTL and testbench



---
 rtl/mux2_pkg.sv | 16 +
 rtl/rr_arb2.sv | 24 ++
 rtl/mux2_rr_stream_sel.sv | 87 ++++++++
 tb/tb_mux2_rr_stream_sel.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mux2_pkg.sv
// Shared definitions for the 2:1 stream-select front end and its arbiter.
package mux2_pkg;

    localparam int DEF_DATA_W = 8;

    // Source index of a beat, matching the downstream mux select encoding.
    localparam logic SEL_I0 = 1'b0;
    localparam logic SEL_I1 = 1'b1;

    // Output buffer occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin grant: a lone request wins, a tie goes to prio.
module rr_arb2
    import mux2_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic gnt_valid,
    output logic gnt_idx
);

    // Pick the winner; prio only matters when both inputs request.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_valid = req0 | req1;
        gnt_idx   = SEL_I0;
        if (req0 && req1) begin
            gnt_idx = prio;
        end else if (req1) begin
            gnt_idx = SEL_I1;
        end
    end

endmodule

// File: rtl/mux2_rr_stream_sel.sv
// Round-robin 2:1 stream selector with a one-entry registered output and an
// exported select s. Optional grant counters cnt0/cnt1 are built when
// MUX2_RR_STREAM_SEL_STATS_EN is defined.
module mux2_rr_stream_sel
    import mux2_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i0_data,
    input  logic              i0_valid,
    output logic              i0_ready,
    input  logic [DATA_W-1:0] i1_data,
    input  logic              i1_valid,
    output logic              i1_ready,
    output logic [DATA_W-1:0] y_data,
    output logic              y_valid,
    input  logic              y_ready,
`ifdef MUX2_RR_STREAM_SEL_STATS_EN
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
`endif
    output logic              s
);

    state_t state;
    logic   prio;
    logic   can_load;
    logic   gnt_valid;
    logic   gnt_idx;
    logic   load;

    rr_arb2 u_arb (
        .req0      (i0_valid),
        .req1      (i1_valid),
        .prio      (prio),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // The buffer can take a beat when empty or when its beat leaves this cycle;
    // reset blocks all acceptance.
    always_comb begin
        can_load = ~rst & ((state == ST_EMPTY) | y_ready);
        load     = can_load & gnt_valid;
        i0_ready = load & (gnt_idx == SEL_I0);
        i1_ready = load & (gnt_idx == SEL_I1);
    end

    assign y_valid = (state == ST_FULL);

    // Output buffer, occupancy and priority pointer update.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state  <= ST_EMPTY;
            y_data <= '0;
            s      <= SEL_I0;
            prio   <= SEL_I0;
        end else if (can_load) begin
            if (gnt_valid) begin
                state  <= ST_FULL;
                y_data <= (gnt_idx == SEL_I1) ? i1_data : i0_data;
                s      <= gnt_idx;
                prio   <= ~gnt_idx;
            end else begin
                state  <= ST_EMPTY;
            end
        end
    end

`ifdef MUX2_RR_STREAM_SEL_STATS_EN
    // Grant counters, bumped on the same edge that loads y; wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (i0_ready) cnt0 <= cnt0 + 1'b1;
            if (i1_ready) cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux2_rr_stream_sel.sv
// Bench for mux2_rr_stream_sel: per-cycle vector table plus a scoreboard that
// tracks accepted beats and matches them against y handshakes.
module tb_mux2_rr_stream_sel;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] i0_data, i1_data, y_data;
    logic              i0_valid, i1_valid, i0_ready, i1_ready;
    logic              y_valid, y_ready, s;
`ifdef MUX2_RR_STREAM_SEL_STATS_EN
    logic [CNT_W-1:0]  cnt0, cnt1;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    mux2_rr_stream_sel #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .i0_data  (i0_data),
        .i0_valid (i0_valid),
        .i0_ready (i0_ready),
        .i1_data  (i1_data),
        .i1_valid (i1_valid),
        .i1_ready (i1_ready),
        .y_data   (y_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
`ifdef MUX2_RR_STREAM_SEL_STATS_EN
        .cnt0     (cnt0),
        .cnt1     (cnt1),
`endif
        .s        (s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: accepted beats in order, each tagged with its source.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sel;
    } beat_t;

    beat_t sb_q[$];

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (y_valid && y_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    beat_t b;
                    b = sb_q.pop_front();
                    check("sb_y_data", 32'(y_data), 32'(b.data));
                    check("sb_s", 32'(s), 32'(b.sel));
                end
            end
            if (i0_valid && i0_ready) sb_q.push_back('{data: i0_data, sel: 1'b0});
            if (i1_valid && i1_ready) sb_q.push_back('{data: i1_data, sel: 1'b1});
        end
    end

    // One row = inputs applied for a cycle and outputs expected in that cycle.
    typedef struct {
        logic              rst;
        logic              v0;
        logic [DATA_W-1:0] d0;
        logic              v1;
        logic [DATA_W-1:0] d1;
        logic              yr;
        logic              e_yv;
        logic [DATA_W-1:0] e_yd;
        logic              e_s;
        logic              e_r0;
        logic              e_r1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic yr,
                       input logic e_yv, input logic [7:0] e_yd, input logic e_s,
                       input logic e_r0, input logic e_r1);
        vec_t v;
        v = '{r, v0, d0, v1, d1, yr, e_yv, e_yd, e_s, e_r0, e_r1};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1, input logic yr);
        rst = r; i0_valid = v0; i0_data = d0; i1_valid = v1; i1_data = d1; y_ready = yr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   rst v0 d0     v1 d1     yr   yv yd     s  r0 r1
        // reset held with both inputs valid
        add(1, 1, 8'h01, 1, 8'h02, 1,   0, 8'h00, 0, 0, 0);
        add(1, 1, 8'h01, 1, 8'h02, 1,   0, 8'h00, 0, 0, 0);
        // contention right after release: i0 first, then alternation
        add(0, 1, 8'hA0, 1, 8'hB0, 1,   0, 8'h00, 0, 1, 0);
        add(0, 1, 8'hA1, 1, 8'hB0, 1,   1, 8'hA0, 0, 0, 1);
        add(0, 1, 8'hA1, 1, 8'hB1, 1,   1, 8'hB0, 1, 1, 0);
        add(0, 1, 8'hA2, 1, 8'hB1, 1,   1, 8'hA1, 0, 0, 1);
        add(0, 1, 8'hA2, 1, 8'hB2, 1,   1, 8'hB1, 1, 1, 0);
        // single stream on i0 (wins although prio points at i1)
        add(0, 1, 8'h11, 0, 8'h00, 1,   1, 8'hA2, 0, 1, 0);
        add(0, 1, 8'h22, 0, 8'h00, 1,   1, 8'h11, 0, 1, 0);
        add(0, 1, 8'h33, 0, 8'h00, 1,   1, 8'h22, 0, 1, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h33, 0, 0, 0);
        // idle: y empties, data and s hold
        add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h33, 0, 0, 0);
        // backpressure on a buffered 0x5A from i1
        add(0, 0, 8'h00, 1, 8'h5A, 1,   0, 8'h33, 0, 0, 1);
        add(0, 1, 8'h66, 1, 8'h77, 0,   1, 8'h5A, 1, 0, 0);
        add(0, 1, 8'h66, 1, 8'h77, 0,   1, 8'h5A, 1, 0, 0);
        add(0, 1, 8'h66, 1, 8'h77, 0,   1, 8'h5A, 1, 0, 0);
        add(0, 1, 8'h66, 1, 8'h77, 1,   1, 8'h5A, 1, 1, 0);
        add(0, 0, 8'h00, 1, 8'h77, 1,   1, 8'h66, 0, 0, 1);
        // load 0xC3, then reset while it sits in y
        add(0, 1, 8'hC3, 0, 8'h00, 1,   1, 8'h77, 1, 1, 0);
        add(1, 1, 8'hD0, 1, 8'hE0, 0,   1, 8'hC3, 0, 0, 0);
        add(0, 1, 8'hD0, 1, 8'hE0, 1,   0, 8'h00, 0, 1, 0);
        add(0, 1, 8'hD1, 1, 8'hE0, 1,   1, 8'hD0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'hE0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'hE0, 1, 0, 0);

        drive(1, 0, 8'h00, 0, 8'h00, 0);
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].yr);
            @(negedge clk);
            check($sformatf("v%0d_y_valid", i), 32'(y_valid),  32'(vecs[i].e_yv));
            check($sformatf("v%0d_y_data", i),  32'(y_data),   32'(vecs[i].e_yd));
            check($sformatf("v%0d_s", i),       32'(s),        32'(vecs[i].e_s));
            check($sformatf("v%0d_i0_ready", i), 32'(i0_ready), 32'(vecs[i].e_r0));
            check($sformatf("v%0d_i1_ready", i), 32'(i1_ready), 32'(vecs[i].e_r1));
            next_cycle();
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        // 17 back-to-back i1-only grants after a fresh reset
        drive(1, 0, 8'h00, 0, 8'h00, 1);
        next_cycle();
        for (int k = 0; k < 17; k++) begin
            drive(0, 0, 8'h00, 1, 8'(8'h40 + k), 1);
            @(negedge clk);
            check($sformatf("stats_i1_ready_%0d", k), 32'(i1_ready), 32'd1);
            next_cycle();
        end
        drive(0, 0, 8'h00, 0, 8'h00, 1);
        @(negedge clk);
        check("stats_last_y", 32'(y_data), 32'h50);
        next_cycle();
        @(negedge clk);
        check("stats_sb_drained", 32'(sb_q.size()), 32'd0);
`ifdef MUX2_RR_STREAM_SEL_STATS_EN
        check("cnt1_wrap", 32'(cnt1), 32'd1);
        check("cnt0_zero", 32'(cnt0), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
